dmem_wait: RTL and testbench

DMEM_WAIT -- requirements
Module: dmem_wait

---
 rtl/dmem_wait.sv | 179 +++++++++++++++++
 tb/tb_dmem_wait.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_wait.sv
// Single-port data memory with a fixed number of wait states per access.
// Supports byte/halfword/word loads and stores and rejects misaligned or reserved sizes.
module dmem_wait #(
  parameter int DEPTH       = 64,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [1:0]  size,
  input  logic        uns,
  input  logic [31:0] addr,
  input  logic [31:0] wd,
  output logic [31:0] rd,
  output logic        ready,
  output logic        busy,
  output logic        err
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] WC = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {IDLE, WAIT, DONE, ERR} state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic        we_q;
  logic        uns_q;
  logic [1:0]  size_q;
  logic [31:0] addr_q;
  logic [31:0] wd_q;

  logic [31:0] mem [DEPTH];

  logic          legal;
  logic [1:0]    a_size;
  logic          a_uns;
  logic [31:0]   a_addr;
  logic [AW-1:0] a_idx;
  logic [31:0]   a_word;
  logic [7:0]    lane_b;
  logic [15:0]   lane_h;
  logic [31:0]   load_val;
  logic [AW-1:0] w_idx;
  logic [3:0]    be;
  logic [31:0]   wdata;
  logic          unused_addr_bits;

  always_comb begin
    legal = 1'b0;
    case (size)
      2'b00:   legal = 1'b1;
      2'b01:   legal = ~addr[0];
      2'b10:   legal = (addr[1:0] == 2'b00);
      default: legal = 1'b0;
    endcase
  end

  // In IDLE the live request is decoded so a zero-wait access can load rd on acceptance.
  always_comb begin
    a_size   = (state == IDLE) ? size : size_q;
    a_uns    = (state == IDLE) ? uns  : uns_q;
    a_addr   = (state == IDLE) ? addr : addr_q;
    a_idx    = a_addr[AW+1:2];
    a_word   = mem[a_idx];
    lane_b   = a_word[{a_addr[1:0], 3'b000} +: 8];
    lane_h   = a_word[{a_addr[1], 4'b0000} +: 16];
    load_val = a_word;
    case (a_size)
      2'b00:   load_val = a_uns ? {24'b0, lane_b} : {{24{lane_b[7]}}, lane_b};
      2'b01:   load_val = a_uns ? {16'b0, lane_h} : {{16{lane_h[15]}}, lane_h};
      default: load_val = a_word;
    endcase
  end

  assign unused_addr_bits = ^a_addr[31:AW+2];

  always_comb begin
    w_idx = addr_q[AW+1:2];
    be    = 4'b1111;
    wdata = wd_q;
    case (size_q)
      2'b00: begin
        be    = 4'b0001 << addr_q[1:0];
        wdata = {4{wd_q[7:0]}};
      end
      2'b01: begin
        be    = addr_q[1] ? 4'b1100 : 4'b0011;
        wdata = {2{wd_q[15:0]}};
      end
      default: begin
        be    = 4'b1111;
        wdata = wd_q;
      end
    endcase
  end

  // Stores commit on the edge leaving DONE; an async reset pulls state out of DONE first.
  always_ff @(posedge clk) begin
    if (state == DONE && we_q) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[w_idx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= 4'd0;
      ready  <= 1'b0;
      err    <= 1'b0;
      busy   <= 1'b0;
      rd     <= 32'd0;
      we_q   <= 1'b0;
      uns_q  <= 1'b0;
      size_q <= 2'b00;
      addr_q <= 32'd0;
      wd_q   <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          ready <= 1'b0;
          err   <= 1'b0;
          rd    <= 32'd0;
          busy  <= 1'b0;
          if (req) begin
            we_q   <= we;
            uns_q  <= uns;
            size_q <= size;
            addr_q <= addr;
            wd_q   <= wd;
            busy   <= 1'b1;
            if (!legal) begin
              state <= ERR;
              cnt   <= 4'd0;
              ready <= 1'b1;
              err   <= 1'b1;
            end else if (WC == 4'd0) begin
              state <= DONE;
              cnt   <= 4'd0;
              ready <= 1'b1;
              rd    <= we ? 32'd0 : load_val;
            end else begin
              state <= WAIT;
              cnt   <= WC;
            end
          end
        end
        WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            state <= DONE;
            ready <= 1'b1;
            rd    <= we_q ? 32'd0 : load_val;
          end
        end
        DONE, ERR: begin
          state <= IDLE;
          ready <= 1'b0;
          err   <= 1'b0;
          busy  <= 1'b0;
          rd    <= 32'd0;
          cnt   <= 4'd0;
        end
        default: begin
          state <= IDLE;
          ready <= 1'b0;
          err   <= 1'b0;
          busy  <= 1'b0;
          rd    <= 32'd0;
          cnt   <= 4'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_wait.sv
// Bench for dmem_wait: byte-array transaction model with per-cycle output compare,
// directed literal cases, randomized traffic, and a zero-wait instance.
module tb_dmem_wait;

  localparam int DEPTH = 64;
  localparam int W     = 2;

  logic        clk   = 1'b0;
  logic        reset = 1'b1;
  logic        req   = 1'b0;
  logic        we    = 1'b0;
  logic        uns   = 1'b0;
  logic [1:0]  size  = 2'b00;
  logic [31:0] addr  = 32'd0;
  logic [31:0] wd    = 32'd0;
  logic [31:0] rd;
  logic        ready, busy, err;

  logic        req0  = 1'b0;
  logic        we0   = 1'b0;
  logic        uns0  = 1'b0;
  logic [1:0]  size0 = 2'b00;
  logic [31:0] addr0 = 32'd0;
  logic [31:0] wd0   = 32'd0;
  logic [31:0] rd0;
  logic        ready0, busy0, err0;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  dmem_wait #(.DEPTH(DEPTH), .WAIT_CYCLES(W)) dut (
    .clk(clk), .reset(reset), .req(req), .we(we), .size(size), .uns(uns),
    .addr(addr), .wd(wd), .rd(rd), .ready(ready), .busy(busy), .err(err)
  );

  dmem_wait #(.DEPTH(DEPTH), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .reset(reset), .req(req0), .we(we0), .size(size0), .uns(uns0),
    .addr(addr0), .wd(wd0), .rd(rd0), .ready(ready0), .busy(busy0), .err(err0)
  );

  // Reference: memory as little-endian bytes; each transaction occupies cycles
  // [accept, accept+W] (or just the accept cycle when rejected), write lands after.
  logic [7:0]  mbytes [DEPTH*4];
  int          cyc      = 0;
  int          resp_cyc = 0;
  bit          have_txn = 1'b0;
  bit          t_err    = 1'b0;
  bit          t_we     = 1'b0;
  logic [31:0] t_rd     = 32'd0;
  int          pw_base  = 0;
  int          pw_n     = 0;
  logic [31:0] pw_data  = 32'd0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("[TB] FAIL %s at t=%0t: got %h, required %h", name, $time, act, exp);
  endtask

  function automatic bit is_legal(input logic [1:0] s, input logic [31:0] a);
    return (s == 2'd0) || (s == 2'd1 && a[0] == 1'b0) || (s == 2'd2 && a[1:0] == 2'b00);
  endfunction

  always @(posedge clk or posedge reset) begin
    bit idle;
    bit lg;
    int base;
    int n;
    if (reset) begin
      have_txn = 1'b0;
    end else begin
      cyc++;
      idle = !have_txn;
      if (have_txn && cyc == resp_cyc + 1) begin
        if (t_we && !t_err)
          for (int k = 0; k < pw_n; k++) mbytes[pw_base+k] = pw_data[8*k +: 8];
        have_txn = 1'b0;
      end
      if (idle && req) begin
        lg       = is_legal(size, addr);
        base     = int'((addr >> 2) % 32'(DEPTH)) * 4 + int'(addr[1:0]);
        n        = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
        t_err    = !lg;
        t_we     = we;
        resp_cyc = cyc + (lg ? W : 0);
        have_txn = 1'b1;
        pw_base  = base;
        pw_n     = n;
        pw_data  = wd;
        t_rd     = 32'd0;
        if (lg && !we) begin
          for (int k = 0; k < n; k++) t_rd = t_rd | (32'(mbytes[base+k]) << (8*k));
          if (n < 4 && !uns && t_rd[8*n-1]) t_rd = t_rd | ~((32'd1 << (8*n)) - 32'd1);
        end
      end
    end
  end

  always @(negedge clk) begin
    logic        e_busy, e_ready, e_err;
    logic [31:0] e_rd;
    e_busy  = 1'b0;
    e_ready = 1'b0;
    e_err   = 1'b0;
    e_rd    = 32'd0;
    if (!reset && have_txn) begin
      e_busy  = 1'b1;
      e_ready = (cyc == resp_cyc);
      e_err   = e_ready && t_err;
      if (e_ready && !t_err && !t_we) e_rd = t_rd;
    end
    checkOutput("busy",  {31'b0, busy},  {31'b0, e_busy});
    checkOutput("ready", {31'b0, ready}, {31'b0, e_ready});
    checkOutput("err",   {31'b0, err},   {31'b0, e_err});
    checkOutput("rd",    rd,             e_rd);
  end

  task automatic applyStimulus(input logic w, input logic [1:0] s, input logic u,
                               input logic [31:0] a, input logic [31:0] d);
    int n;
    n = 0;
    while (have_txn && n < 30) begin
      @(posedge clk);
      #2;
      n++;
    end
    if (have_txn) begin
      total++;
      $display("[TB] FAIL idle_wait: still busy after %0d cycles, required idle", n);
    end
    req  = 1'b1;
    we   = w;
    size = s;
    uns  = u;
    addr = a;
    wd   = d;
    @(posedge clk);
    #2;
    req = 1'b0;
  endtask

  task automatic getResponse(output logic [31:0] r, output logic e, output int lat);
    lat = 0;
    r   = 32'd0;
    e   = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (ready) begin
        r   = rd;
        e   = err;
        lat = n;
        break;
      end
    end
  endtask

  task automatic accessCheck(input string name, input logic w, input logic [1:0] s, input logic u,
                             input logic [31:0] a, input logic [31:0] d,
                             input logic [31:0] exp_rd, input logic exp_err, input int exp_lat);
    logic [31:0] r;
    logic        e;
    int          lat;
    applyStimulus(w, s, u, a, d);
    getResponse(r, e, lat);
    checkOutput({name, "_lat"}, 32'(lat), 32'(exp_lat));
    checkOutput({name, "_rd"}, r, exp_rd);
    checkOutput({name, "_err"}, {31'b0, e}, {31'b0, exp_err});
  endtask

  initial begin
    int r;
    repeat (3) @(posedge clk);
    #2;
    reset = 1'b0;

    for (int i = 0; i < DEPTH; i++) applyStimulus(1'b1, 2'd2, 1'b0, 32'(i * 4), $urandom);

    accessCheck("st_w10",  1'b1, 2'd2, 1'b0, 32'h10,  32'hDEADBEEF, 32'h0,        1'b0, 3);
    accessCheck("ld_w10",  1'b0, 2'd2, 1'b0, 32'h10,  32'h0,        32'hDEADBEEF, 1'b0, 3);
    accessCheck("st_b11",  1'b1, 2'd0, 1'b0, 32'h11,  32'h12345680, 32'h0,        1'b0, 3);
    accessCheck("ld_b11s", 1'b0, 2'd0, 1'b0, 32'h11,  32'h0,        32'hFFFFFF80, 1'b0, 3);
    accessCheck("ld_b11u", 1'b0, 2'd0, 1'b1, 32'h11,  32'h0,        32'h00000080, 1'b0, 3);
    accessCheck("ld_w10b", 1'b0, 2'd2, 1'b0, 32'h10,  32'h0,        32'hDEAD80EF, 1'b0, 3);
    accessCheck("ld_h13",  1'b0, 2'd1, 1'b0, 32'h13,  32'h0,        32'h0,        1'b1, 1);
    accessCheck("ld_s3",   1'b0, 2'd3, 1'b0, 32'h10,  32'h0,        32'h0,        1'b1, 1);
    accessCheck("st_h13",  1'b1, 2'd1, 1'b0, 32'h13,  32'hFFFFFFFF, 32'h0,        1'b1, 1);
    accessCheck("st_w12",  1'b1, 2'd2, 1'b0, 32'h12,  32'hFFFFFFFF, 32'h0,        1'b1, 1);
    accessCheck("ld_w10c", 1'b0, 2'd2, 1'b0, 32'h10,  32'h0,        32'hDEAD80EF, 1'b0, 3);
    accessCheck("st_h12",  1'b1, 2'd1, 1'b0, 32'h12,  32'h5555ABCD, 32'h0,        1'b0, 3);
    accessCheck("ld_h12s", 1'b0, 2'd1, 1'b0, 32'h12,  32'h0,        32'hFFFFABCD, 1'b0, 3);
    accessCheck("ld_h12u", 1'b0, 2'd1, 1'b1, 32'h12,  32'h0,        32'h0000ABCD, 1'b0, 3);
    accessCheck("ld_w10u", 1'b0, 2'd2, 1'b1, 32'h10,  32'h0,        32'hABCD80EF, 1'b0, 3);
    accessCheck("st_w100", 1'b1, 2'd2, 1'b0, 32'h100, 32'h12345678, 32'h0,        1'b0, 3);
    accessCheck("ld_w000", 1'b0, 2'd2, 1'b0, 32'h000, 32'h0,        32'h12345678, 1'b0, 3);
    accessCheck("st_w20",  1'b1, 2'd2, 1'b0, 32'h20,  32'h0BADC0DE, 32'h0,        1'b0, 3);

    // Abort a store in its WAIT cycle; outputs must drop without waiting for a clock edge.
    applyStimulus(1'b1, 2'd2, 1'b0, 32'h20, 32'hCAFEF00D);
    #1 reset = 1'b1;
    #1;
    checkOutput("rst_busy",  {31'b0, busy},  32'd0);
    checkOutput("rst_ready", {31'b0, ready}, 32'd0);
    checkOutput("rst_err",   {31'b0, err},   32'd0);
    checkOutput("rst_rd",    rd,             32'd0);
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;
    accessCheck("ld_w20a", 1'b0, 2'd2, 1'b0, 32'h20, 32'h0, 32'h0BADC0DE, 1'b0, 3);

    applyStimulus(1'b1, 2'd2, 1'b0, 32'h20, 32'hDDDDDDDD);
    repeat (2) @(posedge clk);
    #3 reset = 1'b1;
    @(posedge clk);
    #2 reset = 1'b0;
    accessCheck("ld_w20b", 1'b0, 2'd2, 1'b0, 32'h20, 32'h0, 32'h0BADC0DE, 1'b0, 3);

    for (int i = 0; i < 600; i++) begin
      @(posedge clk);
      #2;
      req  = 1'($urandom_range(0, 1));
      we   = 1'($urandom_range(0, 1));
      uns  = 1'($urandom_range(0, 1));
      r    = int'($urandom_range(0, 7));
      size = (r < 7) ? 2'(r % 3) : 2'd3;
      addr = $urandom;
      wd   = $urandom;
      if ($urandom_range(0, 3) != 0) begin
        if (size == 2'd1) addr[0] = 1'b0;
        if (size == 2'd2) addr[1:0] = 2'b00;
      end
    end
    req = 1'b0;
    repeat (6) @(posedge clk);

    // Zero-wait instance with req held high: accepts every other edge, fields latched.
    #2;
    req0 = 1'b1; we0 = 1'b1; size0 = 2'd2; uns0 = 1'b0;
    addr0 = 32'h4; wd0 = 32'h11111111;
    for (int s = 0; s < 7; s++) begin
      logic        e_rdy;
      logic [31:0] e_rd;
      @(posedge clk);
      #2;
      case (s)
        0: begin addr0 = 32'h8; wd0 = 32'h22222222; end
        2: begin we0 = 1'b0; addr0 = 32'h4; end
        4: addr0 = 32'h8;
        6: req0 = 1'b0;
        default: ;
      endcase
      e_rdy = (s % 2 == 0);
      e_rd  = (s == 4) ? 32'h11111111 : (s == 6) ? 32'h22222222 : 32'h0;
      @(negedge clk);
      checkOutput("z_ready", {31'b0, ready0}, {31'b0, e_rdy});
      checkOutput("z_busy",  {31'b0, busy0},  {31'b0, e_rdy});
      checkOutput("z_err",   {31'b0, err0},   32'd0);
      checkOutput("z_rd",    rd0,             e_rd);
    end

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
